// File: rtl/sysarray_stream_if.sv
// Operand-in / result-out streaming bus for sysarray_stream.
// master = operand producer and result consumer, slave = the array core.
interface sysarray_stream_if #(
  parameter int N  = 2,
  parameter int DW = 4,
  parameter int RW = 2*DW + $clog2(N) + 1
);
  localparam int RWD = $clog2(N);

  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              res_valid;
  logic              res_ready;
  logic [RWD-1:0]    res_row;
  logic [N*RW-1:0]   res_data;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_row, res_data
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_row, res_data
  );
endinterface

// File: rtl/sysarray_stream.sv
// N x N output-stationary systolic multiplier: loads A then B, runs 3N-2 compute cycles, drains C one row per handshake.
// First result row appears 3N-1 cycles after the last B word; a stalled consumer holds res_data stable in DRAIN.
module sysarray_stream #(
  parameter int N  = 2,
  parameter int DW = 4,
  parameter int RW = 2*DW + $clog2(N) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic conf,
  input  logic clear,
  output logic busy,
  output logic done,
  output logic ovf,
  sysarray_stream_if.slave io
);
  localparam int NN   = N*N;
  localparam int IW   = $clog2(NN);
  localparam int SW   = $clog2(3*N-2);
  localparam int RWD  = $clog2(N);
  localparam int PW   = 2*DW;
  localparam int LAST = 3*N-3;

  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] COMPUTE = 2'd2;
  localparam logic [1:0] DRAIN   = 2'd3;

  logic [1:0]     state;
  logic [IW-1:0]  idx;
  logic [SW-1:0]  step;
  logic [RWD-1:0] row;

  logic [DW-1:0]  op_a   [NN];
  logic [DW-1:0]  op_b   [NN];
  logic [DW-1:0]  a_pipe [N][N];
  logic [DW-1:0]  b_pipe [N][N];
  logic [RW-1:0]  acc    [N][N];

  logic [DW-1:0]  feed_a [N];
  logic [DW-1:0]  feed_b [N];
  logic [DW-1:0]  a_in   [N][N];
  logic [DW-1:0]  b_in   [N][N];
  logic [RW:0]    sum    [N][N];
  logic           carry;

  logic in_hs;
  logic res_hs;

  assign io.in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign io.res_valid = (state == DRAIN);
  assign io.res_row   = row;
  assign busy         = (state == COMPUTE);
  assign in_hs        = io.in_valid && io.in_ready;
  assign res_hs       = io.res_valid && io.res_ready;
  assign done         = res_hs && (row == RWD'(N-1)) && !clear && !rst;

  // Skewed edge feed: row i sees A[i][step-i], column j sees B[step-j][j], zero outside the window.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      feed_a[i] = '0;
      feed_b[i] = '0;
      for (int k = 0; k < N; k++) begin
        if (int'(step) == i + k) begin
          feed_a[i] = op_a[i*N + k];
          feed_b[i] = op_b[k*N + i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_pe
      logic [PW-1:0] prod;
      if (gj == 0) begin : g_a_edge
        assign a_in[gi][gj] = feed_a[gi];
      end else begin : g_a_link
        assign a_in[gi][gj] = a_pipe[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign b_in[gi][gj] = feed_b[gj];
      end else begin : g_b_link
        assign b_in[gi][gj] = b_pipe[gi-1][gj];
      end
      assign prod         = PW'(a_in[gi][gj]) * PW'(b_in[gi][gj]);
      assign sum[gi][gj]  = {1'b0, acc[gi][gj]} + (RW+1)'(prod);
    end
  end

  always_comb begin
    carry = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        carry = carry | sum[i][j][RW];
  end

  always_comb begin
    io.res_data = '0;
    for (int j = 0; j < N; j++)
      io.res_data[j*RW +: RW] = acc[row][j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
      idx   <= '0;
      step  <= '0;
      row   <= '0;
      ovf   <= 1'b0;
      for (int k = 0; k < NN; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]    <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end
    end else if (clear) begin
      state <= LOAD_A;
      idx   <= '0;
      step  <= '0;
      row   <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j]    <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end
    end else begin
      case (state)
        LOAD_A: if (in_hs) begin
          op_a[idx] <= io.in_data;
          if (idx == IW'(NN-1)) begin
            idx   <= '0;
            state <= LOAD_B;
            // Overwrite mode starts from zero; accumulate mode keeps the previous C.
            if (!conf)
              for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                  acc[i][j] <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        LOAD_B: if (in_hs) begin
          op_b[idx] <= io.in_data;
          if (idx == IW'(NN-1)) begin
            idx   <= '0;
            step  <= '0;
            state <= COMPUTE;
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++) begin
                a_pipe[i][j] <= '0;
                b_pipe[i][j] <= '0;
              end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        COMPUTE: begin
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
              acc[i][j]    <= sum[i][j][RW-1:0];
              a_pipe[i][j] <= a_in[i][j];
              b_pipe[i][j] <= b_in[i][j];
            end
          if (carry)
            ovf <= 1'b1;
          if (step == SW'(LAST)) begin
            state <= DRAIN;
            row   <= '0;
          end else begin
            step <= step + SW'(1);
          end
        end
        default: if (res_hs) begin
          if (row == RWD'(N-1)) begin
            row   <= '0;
            state <= LOAD_A;
          end else begin
            row <= row + RWD'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sysarray_stream.sv
// Randomised bench for sysarray_stream against a matrix-level reference model (RW narrowed to 9 to reach wrap).
module tb_sysarray_stream;
  localparam int N   = 2;
  localparam int DW  = 4;
  localparam int RW  = 9;
  localparam int NN  = N*N;
  localparam int RWD = $clog2(N);

  logic clk = 1'b0;
  logic rst, conf, clear;
  logic busy, done, ovf;

  sysarray_stream_if #(.N(N), .DW(DW), .RW(RW)) io();

  sysarray_stream #(.N(N), .DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .conf(conf), .clear(clear),
    .busy(busy), .done(done), .ovf(ovf), .io(io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ma [NN];
  int mb [NN];
  int macc [N][N];
  bit movf;

  function automatic void model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        macc[i][j] = 0;
    movf = 1'b0;
  endfunction

  function automatic void model_run(input bit cf);
    int dot, t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (!cf) macc[i][j] = 0;
        dot = 0;
        for (int k = 0; k < N; k++) dot += ma[i*N+k] * mb[k*N+j];
        t = macc[i][j] + dot;
        if (t >= (1 << RW)) movf = 1'b1;
        macc[i][j] = t % (1 << RW);
      end
  endfunction

  function automatic logic [N*RW-1:0] exp_row(input int r);
    logic [N*RW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*RW +: RW] = RW'(macc[r][j]);
    return v;
  endfunction

  function automatic void set_seq();
    for (int k = 0; k < NN; k++) begin
      ma[k] = k + 1;
      mb[k] = k + 1 + NN;
    end
  endfunction

  function automatic void set_rand();
    for (int k = 0; k < NN; k++) begin
      ma[k] = int'($urandom_range(0, 15));
      mb[k] = int'($urandom_range(0, 15));
    end
  endfunction

  task automatic load_words(input int count, input bit gaps);
    int n = 0;
    int guard = 0;
    bit hs;
    while (n < count && guard < 20*count) begin
      io.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      io.in_data  = DW'(n < NN ? ma[n] : mb[n-NN]);
      #1;
      n_checks++;
      if (io.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_in_ready word %0d: got %b want 1", n, io.in_ready);
      end
      hs = io.in_valid && io.in_ready;
      @(negedge clk);
      if (hs) n++;
      guard++;
    end
    io.in_valid = 1'b0;
    n_checks++;
    if (n != count) begin
      n_fail++;
      $display("FAIL load_timeout: accepted %0d words want %0d", n, count);
    end
  endtask

  task automatic wait_results(output bit ok);
    int cyc = 1;
    int bc  = 0;
    ok = 1'b0;
    while (cyc < 10*N + 10) begin
      io.in_valid = 1'($urandom_range(0, 1));
      io.in_data  = DW'($urandom);
      #1;
      if (io.res_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (busy === 1'b1) bc++;
      n_checks++;
      if (io.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL compute_in_ready cycle %0d: got %b want 0", cyc, io.in_ready);
      end
      @(negedge clk);
      cyc++;
    end
    io.in_valid = 1'b0;
    n_checks++;
    if (!ok || cyc != 3*N-1) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles (seen=%0b) want %0d", cyc, ok, 3*N-1);
    end
    n_checks++;
    if (bc != 3*N-2) begin
      n_fail++;
      $display("FAIL busy_cycles: got %0d want %0d", bc, 3*N-2);
    end
  endtask

  task automatic drain_rows(input int stall0, input int max_stall);
    logic [N*RW-1:0] exp;
    int stalls;
    io.in_valid = 1'b0;
    for (int r = 0; r < N; r++) begin
      exp = exp_row(r);
      stalls = (r == 0 && stall0 > 0) ? stall0 : int'($urandom_range(0, max_stall));
      for (int s = 0; s < stalls; s++) begin
        io.res_ready = 1'b0;
        #1;
        n_checks++;
        if (io.res_valid !== 1'b1 || io.res_row !== RWD'(r) || io.res_data !== exp || done !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold row %0d: valid=%b row=%0d data=%h done=%b want 1/%0d/%h/0",
                   r, io.res_valid, io.res_row, io.res_data, done, r, exp);
        end
        @(negedge clk);
      end
      io.res_ready = 1'b1;
      #1;
      n_checks++;
      if (io.res_valid !== 1'b1 || io.res_row !== RWD'(r) || io.res_data !== exp) begin
        n_fail++;
        $display("FAIL row_data row %0d: valid=%b row=%0d data=%h want 1/%0d/%h",
                 r, io.res_valid, io.res_row, io.res_data, r, exp);
      end
      n_checks++;
      if (done !== (r == N-1)) begin
        n_fail++;
        $display("FAIL done_pulse row %0d: got %b want %0b", r, done, (r == N-1));
      end
      @(negedge clk);
    end
    io.res_ready = 1'b0;
    #1;
    n_checks++;
    if (io.res_valid !== 1'b0 || io.in_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_drain: valid=%b in_ready=%b done=%b want 0/1/0", io.res_valid, io.in_ready, done);
    end
    n_checks++;
    if (ovf !== movf) begin
      n_fail++;
      $display("FAIL ovf_flag: got %b want %b", ovf, movf);
    end
  endtask

  task automatic resync();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic run(input bit cf, input int stall0, input int max_stall, input bit gaps);
    bit ok;
    conf = cf;
    load_words(2*NN, gaps);
    model_run(cf);
    wait_results(ok);
    if (ok) drain_rows(stall0, max_stall);
    else resync();
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if (io.in_ready !== 1'b1 || io.res_valid !== 1'b0 || io.res_row !== '0 || io.res_data !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b res_valid=%b row=%0d data=%h busy=%b done=%b ovf=%b want 1/0/0/0/0/0/0",
               tag, io.in_ready, io.res_valid, io.res_row, io.res_data, busy, done, ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; conf = 1'b0; clear = 1'b0;
    io.in_valid = 1'b0; io.in_data = '0; io.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset_state");
    model_clear();
  endtask

  task automatic test_overwrite();
    set_seq();
    run(1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_accumulate();
    set_seq();
    run(1'b1, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    set_rand();
    run(1'b0, 5, 2, 1'b1);
  endtask

  task automatic test_overflow();
    for (int k = 0; k < NN; k++) begin
      ma[k] = 15;
      mb[k] = 15;
    end
    run(1'b0, 0, 1, 1'b1);
    run(1'b1, 0, 1, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    #1;
    check_idle("clear_state");
    set_seq();
    run(1'b1, 0, 1, 1'b0);
  endtask

  task automatic test_abort();
    set_seq();
    conf = 1'b0;
    load_words(2*NN, 1'b1);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    #1;
    check_idle("abort_state");
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (io.res_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet cycle %0d: valid=%b done=%b busy=%b want 0/0/0", c, io.res_valid, done, busy);
      end
    end
    run(1'b0, 0, 1, 1'b0);
  endtask

  task automatic test_reset_midload();
    set_rand();
    conf = 1'b1;
    load_words(NN + 3, 1'b1);
    io.in_valid = 1'b1;
    io.in_data  = DW'($urandom);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    io.in_valid = 1'b0;
    model_clear();
    #1;
    check_idle("midload_reset");
    set_rand();
    run(1'b1, 0, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 8; r++) begin
      set_rand();
      run(1'($urandom_range(0, 1)), 0, 3, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_accumulate();
    test_backpressure();
    test_overflow();
    test_abort();
    test_reset_midload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
